sme_bool_addsub_seq: RTL and testbench

- Multi-cycle sequencer that computes boolean-masked add/sub (a+b, a-b mod 2^XLEN) on SMAX-share operands.
- Reuses the SME ALU's share-wise XOR and shift-left ops and its DOM AND to run a masked Kogge-Stone carry network.
- Owns the intermediate share registers, the round counter and the request handshake.
- Sits between SME instruction issue and the SME ALU, and is invoked for add/sub when smectl_t=0 (boolean masking).

---
 rtl/sme_bool_addsub_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sme_bool_addsub_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_bool_addsub_seq.sv
// sme_bool_addsub_seq
//    Multi-cycle sequencer for boolean-masked add/sub (a+b, a-b mod 2^XLEN) on
//    SMAX-share operands. It drives the SME ALU's share-wise XOR, shift-left
//    and DOM AND ops to evaluate a masked Kogge-Stone carry network. The
//    operand, intermediate and result share registers, the round counter and
//    the request handshake all live here.
//
//    Handshake: a request is taken at a rising edge where valid && ready &&
//    !flush. ready is high only in IDLE. The requester holds valid and its
//    operands until that edge. done is a one-cycle strobe, and rd carries the
//    result shares only while done=1 (zero otherwise).
//
// Ports
//    g_clk, g_resetn           clock, synchronous active-low reset
//    g_clk_req                 clock request (busy or valid pending)
//    valid, ready, op_sub      request handshake; op_sub: 0=add, 1=sub
//    flush                     abort the running operation, no done
//    rs1, rs2                  operand shares (SMAX x XLEN)
//    rd, done                  result shares and completion strobe
//    alu_op_xor/and/shift      one-hot ALU op request while sequencing
//    alu_op_left, alu_shamt    shift direction and amount
//    alu_rs1, alu_rs2          ALU operand shares (held for the whole state)
//    alu_rd                    ALU result shares
module sme_bool_addsub_seq #(
   parameter int XLEN    = 32,
   parameter int SMAX    = 4,
   parameter int AND_LAT = 1
) (
   input  logic                       g_clk,
   input  logic                       g_resetn,
   output logic                       g_clk_req,
   input  logic                       valid,
   output logic                       ready,
   input  logic                       op_sub,
   input  logic                       flush,
   input  logic [SMAX-1:0][XLEN-1:0]  rs1,
   input  logic [SMAX-1:0][XLEN-1:0]  rs2,
   output logic [SMAX-1:0][XLEN-1:0]  rd,
   output logic                       done,
   output logic                       alu_op_xor,
   output logic                       alu_op_and,
   output logic                       alu_op_shift,
   output logic                       alu_op_left,
   output logic [4:0]                 alu_shamt,
   output logic [SMAX-1:0][XLEN-1:0]  alu_rs1,
   output logic [SMAX-1:0][XLEN-1:0]  alu_rs2,
   input  logic [SMAX-1:0][XLEN-1:0]  alu_rd
);

   localparam int L  = $clog2(XLEN);
   localparam int A  = AND_LAT + 1;
   localparam int KW = (L > 1) ? $clog2(L) : 1;
   localparam int WW = $clog2(A + 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_INIT_X = 4'd1;
   localparam logic [3:0] S_INIT_G = 4'd2;
   localparam logic [3:0] S_SHG    = 4'd3;
   localparam logic [3:0] S_ANDG   = 4'd4;
   localparam logic [3:0] S_XORG   = 4'd5;
   localparam logic [3:0] S_SHP    = 4'd6;
   localparam logic [3:0] S_ANDP   = 4'd7;
   localparam logic [3:0] S_SHC    = 4'd8;
   localparam logic [3:0] S_SUM    = 4'd9;
   localparam logic [3:0] S_DONE   = 4'd10;

   logic [3:0]                 state_q;
   logic [KW-1:0]              k_q;
   logic [WW-1:0]              wait_q;
   logic                       sub_q;
   logic [SMAX-1:0][XLEN-1:0]  a_q, b_q, x_q, p_q, g_q, t_q, r_q;

   logic                       accept;
   logic                       and_last;
   logic                       abort;
   logic [4:0]                 round_shamt;
   logic [SMAX-1:0][XLEN-1:0]  a_cap;
   logic [SMAX-1:0][XLEN-1:0]  sum_fix;

   assign ready     = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign g_clk_req = (state_q != S_IDLE) || valid;
   assign rd        = done ? r_q : '0;

   // flush is ignored in IDLE (and blocks a same-cycle request there) and in
   // DONE, where the result strobe always completes.
   assign accept   = valid && ready && !flush;
   assign abort    = flush && (state_q != S_IDLE) && (state_q != S_DONE);
   assign and_last = (wait_q == WW'(A - 1));

   // Shift distance of round k is 2^k.
   assign round_shamt = 5'(1) << k_q;

   // Subtraction is ~(~a + b): only share 0 is inverted, which inverts the
   // unmasked value without ever combining shares.
   always_comb begin
      a_cap = rs1;
      if (op_sub) a_cap[0] = ~rs1[0];
   end

   always_comb begin
      sum_fix = alu_rd;
      if (sub_q) sum_fix[0] = ~alu_rd[0];
   end

   // ALU request decode: purely a function of the state and held registers,
   // so the operands stay stable for the entire state.
   always_comb begin
      alu_op_xor   = 1'b0;
      alu_op_and   = 1'b0;
      alu_op_shift = 1'b0;
      alu_op_left  = 1'b0;
      alu_shamt    = 5'd0;
      alu_rs1      = '0;
      alu_rs2      = '0;
      case (state_q)
         S_INIT_X: begin
            alu_op_xor = 1'b1;
            alu_rs1    = a_q;
            alu_rs2    = b_q;
         end
         S_INIT_G: begin
            alu_op_and = 1'b1;
            alu_rs1    = a_q;
            alu_rs2    = b_q;
         end
         S_SHG: begin
            alu_op_shift = 1'b1;
            alu_op_left  = 1'b1;
            alu_shamt    = round_shamt;
            alu_rs1      = g_q;
         end
         S_ANDG, S_ANDP: begin
            alu_op_and = 1'b1;
            alu_rs1    = p_q;
            alu_rs2    = t_q;
         end
         S_XORG: begin
            alu_op_xor = 1'b1;
            alu_rs1    = g_q;
            alu_rs2    = t_q;
         end
         S_SHP: begin
            alu_op_shift = 1'b1;
            alu_op_left  = 1'b1;
            alu_shamt    = round_shamt;
            alu_rs1      = p_q;
         end
         S_SHC: begin
            alu_op_shift = 1'b1;
            alu_op_left  = 1'b1;
            alu_shamt    = 5'd1;
            alu_rs1      = g_q;
         end
         S_SUM: begin
            alu_op_xor = 1'b1;
            alu_rs1    = x_q;
            alu_rs2    = t_q;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         wait_q  <= '0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         p_q     <= '0;
         g_q     <= '0;
         t_q     <= '0;
         r_q     <= '0;
      end else if (abort) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         wait_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q     <= a_cap;
                  b_q     <= rs2;
                  sub_q   <= op_sub;
                  k_q     <= '0;
                  wait_q  <= '0;
                  state_q <= S_INIT_X;
               end
            end
            S_INIT_X: begin
               // X keeps a^b for the final sum; P starts from the same value.
               x_q     <= alu_rd;
               p_q     <= alu_rd;
               state_q <= S_INIT_G;
            end
            S_INIT_G: begin
               if (and_last) begin
                  g_q     <= alu_rd;
                  wait_q  <= '0;
                  k_q     <= '0;
                  state_q <= S_SHG;
               end else begin
                  wait_q <= wait_q + WW'(1);
               end
            end
            S_SHG: begin
               t_q     <= alu_rd;
               state_q <= S_ANDG;
            end
            S_ANDG: begin
               if (and_last) begin
                  t_q     <= alu_rd;
                  wait_q  <= '0;
                  state_q <= S_XORG;
               end else begin
                  wait_q <= wait_q + WW'(1);
               end
            end
            S_XORG: begin
               // G and P&(G<<2^k) never overlap, so XOR merges like OR.
               g_q <= alu_rd;
               if (k_q == KW'(L - 1)) state_q <= S_SHC;
               else                   state_q <= S_SHP;
            end
            S_SHP: begin
               t_q     <= alu_rd;
               state_q <= S_ANDP;
            end
            S_ANDP: begin
               if (and_last) begin
                  p_q     <= alu_rd;
                  wait_q  <= '0;
                  k_q     <= k_q + KW'(1);
                  state_q <= S_SHG;
               end else begin
                  wait_q <= wait_q + WW'(1);
               end
            end
            S_SHC: begin
               // Carry into bit i is G[i-1]; the MSB carry falls off here.
               t_q     <= alu_rd;
               state_q <= S_SUM;
            end
            S_SUM: begin
               r_q     <= sum_fix;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sme_bool_addsub_seq.sv
// tb_sme_bool_addsub_seq
//    Directed bench for the boolean-masked add/sub sequencer. A small ALU model
//    (share-wise XOR, shift-left, registered DOM-style AND) answers the DUT's
//    ALU requests. Operands are split into random XOR shares; results are
//    recombined and compared to a+b / a-b computed here.
module tb_sme_bool_addsub_seq;

   localparam int XLEN = 32;
   localparam int SMAX = 4;

   typedef logic [SMAX-1:0][XLEN-1:0] shares_t;

   // clock / reset
   logic g_clk = 1'b0;
   logic g_resetn;
   always #5 g_clk = ~g_clk;

   logic        g_clk_req, valid, ready, op_sub, flush, done;
   logic        alu_op_xor, alu_op_and, alu_op_shift, alu_op_left;
   logic [4:0]  alu_shamt;
   shares_t     rs1, rs2, rd, alu_rs1, alu_rs2, alu_rd;

   sme_bool_addsub_seq dut (
      .g_clk        (g_clk),
      .g_resetn     (g_resetn),
      .g_clk_req    (g_clk_req),
      .valid        (valid),
      .ready        (ready),
      .op_sub       (op_sub),
      .flush        (flush),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .done         (done),
      .alu_op_xor   (alu_op_xor),
      .alu_op_and   (alu_op_and),
      .alu_op_shift (alu_op_shift),
      .alu_op_left  (alu_op_left),
      .alu_shamt    (alu_shamt),
      .alu_rs1      (alu_rs1),
      .alu_rs2      (alu_rs2),
      .alu_rd       (alu_rd)
   );

   // ALU model. The AND result is registered once, so it is only correct in
   // the second cycle the operands are held.
   shares_t and_now, and_pipe;
   always_comb begin
      and_now = '0;
      for (int i = 0; i < SMAX; i++)
         for (int j = 0; j < SMAX; j++)
            and_now[i] = and_now[i] ^ (alu_rs1[i] & alu_rs2[j]);
   end
   always @(posedge g_clk) and_pipe <= and_now;

   always_comb begin
      alu_rd = '0;
      if (alu_op_xor) begin
         for (int i = 0; i < SMAX; i++) alu_rd[i] = alu_rs1[i] ^ alu_rs2[i];
      end else if (alu_op_and) begin
         alu_rd = and_pipe;
      end else if (alu_op_shift && alu_op_left) begin
         for (int i = 0; i < SMAX; i++) alu_rd[i] = alu_rs1[i] << alu_shamt;
      end
   end

   // strobe monitor: no op in IDLE/DONE, exactly one op while sequencing
   int   strobe_err = 0;
   int   and_issues = 0;
   logic and_prev   = 1'b0;
   logic mon_en     = 1'b0;
   always @(negedge g_clk) begin
      if (mon_en && g_resetn) begin
         if (alu_op_and && !and_prev) and_issues <= and_issues + 1;
         if (ready || done) begin
            if ((alu_op_xor | alu_op_and | alu_op_shift) || alu_shamt != 5'd0)
               strobe_err <= strobe_err + 1;
         end else if ((int'(alu_op_xor) + int'(alu_op_and) + int'(alu_op_shift)) != 1) begin
            strobe_err <= strobe_err + 1;
         end
      end
      and_prev <= alu_op_and;
   end

   // scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic shares_t split(input logic [XLEN-1:0] v);
      shares_t s;
      logic [XLEN-1:0] acc;
      acc = v;
      for (int i = 1; i < SMAX; i++) begin
         s[i] = $urandom;
         acc  = acc ^ s[i];
      end
      s[0] = acc;
      return s;
   endfunction

   function automatic logic [XLEN-1:0] unmask(input shares_t s);
      logic [XLEN-1:0] acc;
      acc = '0;
      for (int i = 0; i < SMAX; i++) acc = acc ^ s[i];
      return acc;
   endfunction

   // driver tasks
   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic start_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sub);
      rs1    = split(a);
      rs2    = split(b);
      op_sub = sub;
      valid  = 1'b1;
   endtask

   // Returns 1 once the request has been taken at an edge.
   task automatic wait_accept(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (ready && valid && !flush) ok = 1'b1;
         step();
      end
   endtask

   // Cycle index (1 = first cycle after the accepting edge) at which done is seen.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 200) begin
         step();
         cyc++;
      end
   endtask

   task automatic do_op(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic sub, output int cyc, output int ands);
      logic ok;
      int   and0;
      logic [XLEN-1:0] exp;
      exp = sub ? (a - b) : (a + b);
      start_req(a, b, sub);
      wait_accept(ok);
      chk({tag, "_accept"}, 32'(ok), 32'd1);
      valid = 1'b0;
      rs1   = split($urandom);
      rs2   = split($urandom);
      and0  = and_issues;
      wait_done(cyc);
      chk({tag, "_result"}, unmask(rd), exp);
      ands = and_issues - and0;
      step();
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int cyc, ands, n;
      logic ok;
      logic [XLEN-1:0] x, a, b;
      logic s;

      g_resetn = 1'b0;
      valid    = 1'b0;
      op_sub   = 1'b0;
      flush    = 1'b0;
      rs1      = '0;
      rs2      = '0;
      repeat (3) step();

      // reset state
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd", unmask(rd) | rd[0] | rd[1], 32'd0);
      chk("rst_ops", {29'd0, alu_op_xor, alu_op_and, alu_op_shift}, 32'd0);
      chk("rst_shamt", 32'(alu_shamt), 32'd0);
      chk("rst_clk_req_idle", 32'(g_clk_req), 32'd0);
      valid = 1'b1;
      #1;
      chk("rst_clk_req_valid", 32'(g_clk_req), 32'd1);
      step();
      chk("rst_no_accept", 32'(ready), 32'd1);
      valid    = 1'b0;
      g_resetn = 1'b1;
      mon_en   = 1'b1;
      step();

      // 5 + 3: latency and AND count
      do_op("add_5_3", 32'd5, 32'd3, 1'b0, cyc, ands);
      chk("add_5_3_latency", 32'(cyc), 32'd38);
      chk("add_5_3_and_issues", 32'(ands), 32'd10);
      chk("add_5_3_ready_back", 32'(ready), 32'd1);

      // carry chains / wrap
      do_op("add_ffffffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, cyc, ands);
      do_op("add_7fffffff_1", 32'h7FFF_FFFF, 32'd1, 1'b0, cyc, ands);
      do_op("add_aaaa_5555", 32'hAAAA_AAAA, 32'h5555_5556, 1'b0, cyc, ands);

      // subtraction
      do_op("sub_3_5", 32'd3, 32'd5, 1'b1, cyc, ands);
      chk("sub_3_5_latency", 32'(cyc), 32'd38);
      do_op("sub_80000000_1", 32'h8000_0000, 32'd1, 1'b1, cyc, ands);
      x = $urandom;
      do_op("sub_x_x", x, x, 1'b1, cyc, ands);

      // request held while busy is taken only after DONE
      start_req(32'd100, 32'd23, 1'b0);
      wait_accept(ok);
      chk("held_first_accept", 32'(ok), 32'd1);
      start_req(32'd7, 32'd9, 1'b1);
      chk("held_busy_ready", 32'(ready), 32'd0);
      wait_done(cyc);
      chk("held_first_result", unmask(rd), 32'd123);
      chk("held_first_latency", 32'(cyc), 32'd38);
      wait_accept(ok);
      chk("held_second_accept", 32'(ok), 32'd1);
      valid = 1'b0;
      wait_done(cyc);
      chk("held_second_result", unmask(rd), 32'hFFFF_FFFE);
      step();

      // flush in IDLE blocks a same-cycle request
      start_req(32'd1, 32'd2, 1'b0);
      flush = 1'b1;
      step();
      chk("flush_idle_not_taken", 32'(ready), 32'd1);
      flush = 1'b0;
      valid = 1'b0;

      // flush in cycle 10 of an operation
      start_req(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      wait_accept(ok);
      valid = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ready", 32'(ready), 32'd1);
      chk("flush_done", 32'(done), 32'd0);
      chk("flush_rd", unmask(rd) | rd[0], 32'd0);
      do_op("after_flush", 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, cyc, ands);
      chk("after_flush_latency", 32'(cyc), 32'd38);

      // flush during DONE does not cut the strobe short
      start_req(32'd40, 32'd2, 1'b0);
      wait_accept(ok);
      valid = 1'b0;
      wait_done(cyc);
      flush = 1'b1;
      chk("flush_in_done_result", unmask(rd), 32'd42);
      step();
      flush = 1'b0;
      chk("flush_in_done_idle", 32'(ready), 32'd1);

      // reset at cycle 20, with a new request already held
      start_req(32'd11, 32'd22, 1'b0);
      wait_accept(ok);
      valid = 1'b0;
      repeat (19) step();
      g_resetn = 1'b0;
      start_req(32'h0000_0010, 32'h0000_0020, 1'b1);
      step();
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_rd", unmask(rd) | rd[0], 32'd0);
      g_resetn = 1'b1;
      wait_accept(ok);
      chk("midrst_held_accept", 32'(ok), 32'd1);
      valid = 1'b0;
      wait_done(cyc);
      chk("midrst_held_result", unmask(rd), 32'hFFFF_FFF0);
      chk("midrst_held_latency", 32'(cyc), 32'd38);
      step();

      // random operands, fresh share splits
      n = 300;
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         s = 1'($urandom_range(0, 1));
         do_op($sformatf("rand%0d", i), a, b, s, cyc, ands);
      end

      chk("strobe_rules", 32'(strobe_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
